// File: rtl/imm_decode_buf_if.sv
// imm_decode_buf_pkg / imm_decode_buf_if
// Shared types and the handshake bundle for the RV32 immediate-decode buffer.
//   master : instruction source + result sink (drives in_*, flush, out_ready)
//   slave  : the buffer (drives in_ready, out_*)
package imm_decode_buf_pkg;
  typedef logic [31:0] instr_t;

  typedef enum logic [2:0] {
    I_TYPE     = 3'd0,
    S_TYPE     = 3'd1,
    B_TYPE     = 3'd2,
    U_TYPE     = 3'd3,
    J_TYPE     = 3'd4,
    CSR_I_TYPE = 3'd5
  } instr_format_t;

  // One buffered, already-decoded instruction.
  typedef struct packed {
    instr_t        instr;
    logic [31:0]   pc;
    instr_format_t fmt;
    logic [31:0]   imm;
    logic          illegal;
  } entry_t;
endpackage

interface imm_decode_buf_if;
  logic                              in_valid;
  logic                              in_ready;
  imm_decode_buf_pkg::instr_t        in_instr;
  logic [31:0]                       in_pc;
  logic                              flush;
  logic                              out_valid;
  logic                              out_ready;
  imm_decode_buf_pkg::instr_t        out_instr;
  logic [31:0]                       out_pc;
  imm_decode_buf_pkg::instr_format_t out_format;
  logic [31:0]                       out_imm;
  logic                              out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_format, out_imm, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_format, out_imm, out_illegal
  );
endinterface

// File: rtl/imm_decode_buf.sv
// imm_decode_buf
// Two-entry in-order instruction buffer that decodes the RV32 immediate format
// and value on the way in, so the stored entries already carry format/imm/illegal.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   bus.slave : in_valid/in_ready/in_instr/in_pc/flush (upstream),
//               out_valid/out_ready/out_instr/out_pc/out_format/out_imm/out_illegal (downstream)
// Parameter ZICSR_EN: when 0, SYSTEM opcodes other than funct3=000 are illegal.
module imm_decode_buf
  import imm_decode_buf_pkg::*;
#(
  parameter bit ZICSR_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  imm_decode_buf_if.slave   bus
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t state, state_nx;
  entry_t head, slot1, dec;
  logic   in_ready_q;
  logic   accept, pop;
  logic   ld_head_in, ld_head_s1, ld_s1_in;

  function automatic entry_t decode(instr_t i, logic [31:0] pc);
    entry_t e;
    e.instr   = i;
    e.pc      = pc;
    e.fmt     = I_TYPE;
    e.imm     = '0;
    e.illegal = 1'b0;
    case (i[6:0])
      7'b0110111, 7'b0010111: begin
        e.fmt = U_TYPE;
        e.imm = {i[31:12], 12'b0};
      end
      7'b1101111: begin
        e.fmt = J_TYPE;
        e.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      end
      7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111: begin
        e.imm = {{20{i[31]}}, i[31:20]};
      end
      7'b1100011: begin
        e.fmt = B_TYPE;
        e.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      end
      7'b0100011: begin
        e.fmt = S_TYPE;
        e.imm = {{20{i[31]}}, i[31:25], i[11:7]};
      end
      7'b1110011: begin
        if (!ZICSR_EN && (i[14:12] != 3'b000)) begin
          e.illegal = 1'b1;
        end else if (i[14]) begin
          // CSRR*I: the rs1 field is a 5-bit unsigned immediate
          e.fmt = CSR_I_TYPE;
          e.imm = {27'b0, i[19:15]};
        end else begin
          e.imm = {{20{i[31]}}, i[31:20]};
        end
      end
      7'b0110011: ; // OP: legal, no immediate
      default: e.illegal = 1'b1;
    endcase
    return e;
  endfunction

  assign dec    = decode(bus.in_instr, bus.in_pc);
  assign accept = bus.in_valid && in_ready_q;
  assign pop    = (state != EMPTY) && bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    ld_head_in = 1'b0;
    ld_head_s1 = 1'b0;
    ld_s1_in   = 1'b0;
    case (state)
      EMPTY: if (accept) begin
        state_nx   = ONE;
        ld_head_in = 1'b1;
      end
      ONE: begin
        if (accept && pop) begin
          ld_head_in = 1'b1;           // new entry replaces the departing head
        end else if (accept) begin
          state_nx = FULL;
          ld_s1_in = 1'b1;
        end else if (pop) begin
          state_nx = EMPTY;
        end
      end
      FULL: if (pop) begin
        state_nx   = ONE;
        ld_head_s1 = 1'b1;
      end
      default: state_nx = EMPTY;
    endcase
    // Flush drops everything, including whatever moved this cycle.
    if (bus.flush) begin
      state_nx   = EMPTY;
      ld_head_in = 1'b0;
      ld_head_s1 = 1'b0;
      ld_s1_in   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head       <= '0;
      slot1      <= '0;
      in_ready_q <= 1'b1;
    end else begin
      if (ld_head_in)      head <= dec;
      else if (ld_head_s1) head <= slot1;
      if (ld_s1_in)        slot1 <= dec;
      // Registered ready tracks the next state so it equals (state != FULL).
      in_ready_q <= (state_nx != FULL);
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = (state != EMPTY);
  assign bus.out_instr   = head.instr;
  assign bus.out_pc      = head.pc;
  assign bus.out_format  = head.fmt;
  assign bus.out_imm     = head.imm;
  assign bus.out_illegal = head.illegal;

endmodule

// File: tb/tb_imm_decode_buf.sv
// tb_imm_decode_buf
// Directed scoreboard bench. u_dut1 (ZICSR_EN=1) carries the main sequence;
// u_dut0 (ZICSR_EN=0) checks the Zicsr-disabled decode.
module tb_imm_decode_buf;
  import imm_decode_buf_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  imm_decode_buf_if if1 ();
  imm_decode_buf_if if0 ();

  imm_decode_buf #(.ZICSR_EN(1'b1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  imm_decode_buf #(.ZICSR_EN(1'b0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));

  int n_checks = 0;
  int n_fails  = 0;
  int pops     = 0;
  int cyc      = 0;
  int pop_cyc_prev = 0;
  int pop_cyc_last = 0;
  entry_t sb[$];

  logic   prev_hold = 1'b0;
  entry_t prev_head;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: a pop happens at the next rising edge whenever
  // out_valid && out_ready holds at the falling edge (flush discards it).
  always @(negedge clk) begin
    entry_t e;
    cyc++;
    if (!rst && if1.out_valid) begin
      if (prev_hold) begin
        check("hold_instr", if1.out_instr, prev_head.instr);
        check("hold_imm", if1.out_imm, prev_head.imm);
      end
      if (if1.out_ready && !if1.flush) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          check("out_instr", if1.out_instr, e.instr);
          check("out_pc", if1.out_pc, e.pc);
          check("out_format", 32'(if1.out_format), 32'(e.fmt));
          check("out_imm", if1.out_imm, e.imm);
          check("out_illegal", 32'(if1.out_illegal), 32'(e.illegal));
        end
        pops++;
        pop_cyc_prev = pop_cyc_last;
        pop_cyc_last = cyc;
      end
      prev_hold = !if1.out_ready;
      prev_head.instr = if1.out_instr;
      prev_head.imm   = if1.out_imm;
    end else begin
      prev_hold = 1'b0;
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [31:0] i, input logic [31:0] p, input instr_format_t f,
                      input logic [31:0] imm, input logic ill);
    entry_t e;
    e.instr = i; e.pc = p; e.fmt = f; e.imm = imm; e.illegal = ill;
    if1.in_valid = 1'b1;
    if1.in_instr = i;
    if1.in_pc    = p;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (if1.in_ready) begin
        sb.push_back(e);
        @(posedge clk);
        #1;
        if1.in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    if1.in_valid = 1'b0;
    check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (!if1.out_valid && sb.size() == 0) break;
    end
    @(posedge clk);
    #1;
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int p0;
    if1.in_valid = 1'b0; if1.in_instr = '0; if1.in_pc = '0; if1.flush = 1'b0; if1.out_ready = 1'b0;
    if0.in_valid = 1'b0; if0.in_instr = '0; if0.in_pc = '0; if0.flush = 1'b0; if0.out_ready = 1'b1;

    // Reset state, observed while reset is still asserted
    #1 rst = 1'b1;
    #2;
    check("rst_out_valid", 32'(if1.out_valid), 32'd0);
    check("rst_in_ready", 32'(if1.in_ready), 32'd1);
    check("rst_illegal", 32'(if1.out_illegal), 32'd0);
    check("rst_imm", if1.out_imm, 32'd0);
    check("rst_instr", if1.out_instr, 32'd0);
    check("rst_pc", if1.out_pc, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // addi x1,x0,-1 : visible the cycle after acceptance
    if1.out_ready = 1'b1;
    send(32'hFFF00093, 32'h0000_1000, I_TYPE, 32'hFFFFFFFF, 1'b0);
    check("lat_out_valid", 32'(if1.out_valid), 32'd1);
    drain();

    // lui then beq -4 back-to-back, popped on consecutive cycles
    p0 = pops;
    send(32'h123450B7, 32'h0000_1004, U_TYPE, 32'h12345000, 1'b0);
    send(32'hFE000EE3, 32'h0000_1008, B_TYPE, 32'hFFFFFFFC, 1'b0);
    drain();
    check("b2b_pops", 32'(pops - p0), 32'd2);
    check("b2b_consecutive", 32'(pop_cyc_last - pop_cyc_prev), 32'd1);

    // More formats: csrrwi, illegal opcode, sw -4, jal +8, auipc, add
    send(32'h3002D073, 32'h0000_2000, CSR_I_TYPE, 32'h00000005, 1'b0);
    send(32'h0000007F, 32'h0000_2004, I_TYPE, 32'h00000000, 1'b1);
    send(32'hFE112E23, 32'h0000_2008, S_TYPE, 32'hFFFFFFFC, 1'b0);
    send(32'h0080006F, 32'h0000_200C, J_TYPE, 32'h00000008, 1'b0);
    send(32'hFFFFF117, 32'h0000_2010, U_TYPE, 32'hFFFFF000, 1'b0);
    send(32'h002081B3, 32'h0000_2014, I_TYPE, 32'h00000000, 1'b0);
    drain();

    // ZICSR_EN=0: csrrwi illegal, ecall still legal
    if0.in_valid = 1'b1; if0.in_instr = 32'h3002D073; if0.in_pc = 32'h0000_3000;
    @(posedge clk);
    #1 if0.in_valid = 1'b0;
    check("nocsr_valid", 32'(if0.out_valid), 32'd1);
    check("nocsr_illegal", 32'(if0.out_illegal), 32'd1);
    check("nocsr_imm", if0.out_imm, 32'd0);
    if0.in_valid = 1'b1; if0.in_instr = 32'h00000073;
    @(posedge clk);
    #1 if0.in_valid = 1'b0;
    check("ecall_illegal", 32'(if0.out_illegal), 32'd0);
    check("ecall_format", 32'(if0.out_format), 32'(I_TYPE));

    // Backpressure: two accepted, third waits until out_ready rises
    p0 = pops;
    if1.out_ready = 1'b0;
    send(32'h00500113, 32'h0000_4000, I_TYPE, 32'h00000005, 1'b0);
    send(32'h00A00193, 32'h0000_4004, I_TYPE, 32'h0000000A, 1'b0);
    check("full_in_ready", 32'(if1.in_ready), 32'd0);
    fork
      send(32'h80000213, 32'h0000_4008, I_TYPE, 32'hFFFFF800, 1'b0);
      begin
        repeat (3) @(posedge clk);
        #1 if1.out_ready = 1'b1;
      end
    join
    drain();
    check("bp_pops", 32'(pops - p0), 32'd3);

    // Flush while FULL with a same-cycle offer and pop
    if1.out_ready = 1'b0;
    send(32'h00100093, 32'h0000_5000, I_TYPE, 32'h00000001, 1'b0);
    send(32'h00200093, 32'h0000_5004, I_TYPE, 32'h00000002, 1'b0);
    p0 = pops;
    if1.in_valid = 1'b1; if1.in_instr = 32'h00300093; if1.in_pc = 32'h0000_5008;
    if1.out_ready = 1'b1; if1.flush = 1'b1;
    @(posedge clk);
    #1;
    if1.flush = 1'b0; if1.in_valid = 1'b0;
    sb.delete();
    check("flush_out_valid", 32'(if1.out_valid), 32'd0);
    check("flush_in_ready", 32'(if1.in_ready), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    check("flush_no_emit", 32'(pops - p0), 32'd0);
    check("flush_still_empty", 32'(if1.out_valid), 32'd0);

    // Asynchronous reset mid-cycle while ONE
    if1.out_ready = 1'b0;
    send(32'h00700093, 32'h0000_6000, I_TYPE, 32'h00000007, 1'b0);
    check("one_valid", 32'(if1.out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(if1.out_valid), 32'd0);
    check("arst_in_ready", 32'(if1.in_ready), 32'd1);
    sb.delete();
    if1.in_valid = 1'b1; if1.in_instr = 32'h123450B7; if1.in_pc = 32'h0000_6004;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    if1.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("no_accept_in_rst", 32'(if1.out_valid), 32'd0);
    if1.out_ready = 1'b1;
    send(32'hFFF00093, 32'h0000_7000, I_TYPE, 32'hFFFFFFFF, 1'b0);
    check("post_rst_valid", 32'(if1.out_valid), 32'd1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/imm_decode_buf.md
IMM_DECODE_BUF -- requirements
Module: imm_decode_buf

Interface
REQ-001 Parameter ZICSR_EN, default 1, enables Zicsr decode; when 0, SYSTEM with funct3!=000 SHALL be flagged illegal.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  upstream instruction valid.
REQ-005 in_ready  output  1  buffer can accept; registered, equals (state!=FULL).
REQ-006 in_instr  input  32 (instr_t)  instruction word.
REQ-007 in_pc  input  32  instruction address, carried unmodified.
REQ-008 flush  input  1  synchronous discard of all buffered entries.
REQ-009 out_valid  output  1  head entry valid.
REQ-010 out_ready  input  1  downstream accepts head entry.
REQ-011 out_instr / out_pc  output  32 each  head entry instruction and PC.
REQ-012 out_format  output  instr_format_t  decoded immediate format of head entry.
REQ-013 out_imm  output  32  extracted 32-bit immediate of head entry.
REQ-014 out_illegal  output  1  head entry opcode unsupported.

Function
REQ-015 2-entry in-order buffer; states EMPTY, ONE, FULL; one accept when in_valid&&in_ready, one pop when out_valid&&out_ready.
REQ-016 Decode and immediate extraction SHALL occur on the input side, before the entry is written; stored entries carry format, imm, illegal.
REQ-017 Format from opcode in_instr[6:0]: 0110111/0010111 -> U_TYPE; 1101111 -> J_TYPE; 1100111, 0000011, 0010011, 0001111 -> I_TYPE; 1100011 -> B_TYPE; 0100011 -> S_TYPE; 1110011 with funct3[2]=1 -> CSR_I_TYPE, else I_TYPE.
REQ-018 Opcode 0110011 (OP) SHALL decode legal with imm=0, format I_TYPE (don't-care to consumers).
REQ-019 Any other opcode SHALL set illegal=1, imm=0, format I_TYPE.
REQ-020 Immediates: I/S/B/J sign-extended from instr[31]; U = instr[31:12]<<12; CSR_I = zero-extended instr[19:15].
REQ-021 Latency: entry accepted in cycle N into EMPTY appears with out_valid=1 in cycle N+1; no combinational in->out path.
REQ-022 Transitions: EMPTY+accept->ONE; ONE+accept only->FULL; ONE+pop only->EMPTY; ONE+accept+pop->ONE (new entry becomes head next cycle); FULL+pop->ONE; FULL never accepts.
REQ-023 out_valid = (state!=EMPTY); out_* data SHALL be stable while out_valid=1 and out_ready=0.
REQ-024 flush=1 SHALL force EMPTY next cycle; a same-cycle accept and pop SHALL be discarded (in_ready may be high; data dropped).
REQ-025 When out_valid=0, out_instr/out_pc/out_format/out_imm/out_illegal are don't-care.

Reset
REQ-026 rst asserted SHALL immediately force state EMPTY: out_valid=0, in_ready=1, out_illegal=0, out_imm=0, out_instr=0, out_pc=0.
REQ-027 No accept SHALL occur while rst=1; reset mid-operation discards all entries; first accept possible in first clock edge with rst=0.

Verification
REQ-028 Push 0xFFF00093 (addi x1,x0,-1) into EMPTY, out_ready=1 -> next cycle out_valid=1, format I_TYPE, imm 0xFFFFFFFF, illegal 0.
REQ-029 Push 0x123450B7 (lui), then 0xFE000EE3 (beq -4) back-to-back -> U_TYPE imm 0x12345000, then B_TYPE imm 0xFFFFFFFC, consecutive cycles, in order.
REQ-030 Push 0x3002D073 (csrrwi x0,0x300,5) with ZICSR_EN=1 -> CSR_I_TYPE imm 0x00000005; same with ZICSR_EN=0 -> illegal 1, imm 0; push 0x0000007F -> illegal 1, imm 0.
REQ-031 out_ready=0, offer 3 instructions -> two accepted, in_ready=0 from cycle after second accept; raise out_ready -> three popped in original order, no loss/duplication.
REQ-032 FULL, assert flush with in_valid=1 and out_ready=1 -> next cycle out_valid=0, in_ready=1, no entry from that cycle ever emitted.
REQ-033 Assert rst asynchronously mid-cycle while ONE -> out_valid drops before next edge; after release, buffer behaves as EMPTY.
